// File: rtl/cg_enable_ctrl.sv
// -----------------------------------------------------------------------------
// cg_enable_ctrl
//   Producer side of an ICG enable interface. Watches the gated block for
//   sustained idleness (with hysteresis), asks it to quiesce, then drops the
//   clock enable. Wakes the clock on demand and acknowledges requesters only
//   once the clock has been running for WAKE_CYCLES cycles.
//   Lives in the always-on domain next to the ICG. All outputs are registered
//   so the ICG enable is glitch-free.
//
// Optional feature (macro CG_STATS_EN):
//   defined   -> gate_events_o / gated_cycles_o are saturating statistics
//   undefined -> both tied to 0, no counter flops
//
// Ports:
//   clk             free-running clock
//   rst_n           asynchronous active-low reset
//   busy_i          gated block has work pending / in flight
//   wake_req_i      4-phase wake request
//   wake_ack_o      4-phase wake acknowledge (only ever high in RUN)
//   quiesce_req_o   ask block to drain and park
//   quiesce_ack_i   block confirms safe-to-gate
//   force_on_i      software override, keeps clock running
//   cg_en_o         ICG enable, 1 = clock running
//   gated_o         high while clock is gated
//   gate_events_o   number of entries into the gated state
//   gated_cycles_o  number of cycles with cg_en_o = 0
// -----------------------------------------------------------------------------
module cg_enable_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int STAT_W      = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                busy_i,
   input  logic                wake_req_i,
   output logic                wake_ack_o,
   output logic                quiesce_req_o,
   input  logic                quiesce_ack_i,
   input  logic                force_on_i,
   output logic                cg_en_o,
   output logic                gated_o,
   output logic [STAT_W-1:0]   gate_events_o,
   output logic [2*STAT_W-1:0] gated_cycles_o
);

   localparam int ICNT_W = $clog2(IDLE_CYCLES + 1);
   localparam int WCNT_W = $clog2(WAKE_CYCLES + 1);
   localparam logic [ICNT_W-1:0] IDLE_LAST = ICNT_W'(IDLE_CYCLES - 1);
   localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RUN,
      S_IDLE_WAIT,
      S_QUIESCE,
      S_GATED,
      S_WAKE
   } state_e;

   state_e              state_q, state_d;
   logic [ICNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [WCNT_W-1:0]   wake_cnt_q, wake_cnt_d;
   logic                cg_en_q, quiesce_req_q, wake_ack_q, gated_q;

   logic wake, idle;
   assign wake = wake_req_i | force_on_i;
   assign idle = ~busy_i & ~wake;

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      case (state_q)
         S_RUN: begin
            if (idle) begin
               state_d    = S_IDLE_WAIT;
               idle_cnt_d = '0;
            end
         end
         S_IDLE_WAIT: begin
            if (!idle) begin
               state_d    = S_RUN;
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
               state_d    = S_QUIESCE;
               idle_cnt_d = '0;
            end else if (idle_cnt_q != '1) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         S_QUIESCE: begin
            // A wake request aborts gating even if the ack lands in the same cycle.
            if (wake) begin
               state_d = S_RUN;
            end else if (quiesce_ack_i && !busy_i) begin
               state_d = S_GATED;
            end
         end
         S_GATED: begin
            if (wake || busy_i) begin
               state_d    = S_WAKE;
               wake_cnt_d = '0;
            end
         end
         S_WAKE: begin
            if (wake_cnt_q == WAKE_LAST) begin
               state_d = S_RUN;
            end else if (wake_cnt_q != '1) begin
               wake_cnt_d = wake_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so the enable
   // changes exactly on the edge that changes state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RUN;
         idle_cnt_q    <= '0;
         wake_cnt_q    <= '0;
         cg_en_q       <= 1'b1;
         quiesce_req_q <= 1'b0;
         wake_ack_q    <= 1'b0;
         gated_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idle_cnt_q    <= idle_cnt_d;
         wake_cnt_q    <= wake_cnt_d;
         cg_en_q       <= (state_d != S_GATED);
         quiesce_req_q <= (state_d == S_QUIESCE) || (state_d == S_GATED);
         gated_q       <= (state_d == S_GATED);
         // Ack only for a request seen while already settled in RUN.
         wake_ack_q    <= (state_q == S_RUN) && (state_d == S_RUN) && wake_req_i;
      end
   end

   assign cg_en_o       = cg_en_q;
   assign quiesce_req_o = quiesce_req_q;
   assign wake_ack_o    = wake_ack_q;
   assign gated_o       = gated_q;

`ifdef CG_STATS_EN
   logic                gate_entry;
   logic [STAT_W-1:0]   gate_events_q;
   logic [2*STAT_W-1:0] gated_cycles_q;

   assign gate_entry = (state_q == S_QUIESCE) && (state_d == S_GATED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_events_q  <= '0;
         gated_cycles_q <= '0;
      end else begin
         if (gate_entry && (gate_events_q != '1)) begin
            gate_events_q <= gate_events_q + 1'b1;
         end
         if (!cg_en_q && (gated_cycles_q != '1)) begin
            gated_cycles_q <= gated_cycles_q + 1'b1;
         end
      end
   end

   assign gate_events_o  = gate_events_q;
   assign gated_cycles_o = gated_cycles_q;
`else
   assign gate_events_o  = '0;
   assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_cg_enable_ctrl.sv
module tb_cg_enable_ctrl;

   localparam int IDLE_CYCLES = 16;
   localparam int WAKE_CYCLES = 2;
   localparam int STAT_W      = 16;

   localparam int P_ON   = 0;  // clock running, streak counts idle samples
   localparam int P_PARK = 1;  // quiesce requested
   localparam int P_OFF  = 2;  // clock gated
   localparam int P_WARM = 3;  // clock restarted, settling

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                busy_i = 1'b0;
   logic                wake_req_i = 1'b0;
   logic                quiesce_ack_i = 1'b0;
   logic                force_on_i = 1'b0;
   logic                wake_ack_o, quiesce_req_o, cg_en_o, gated_o;
   logic [STAT_W-1:0]   gate_events_o;
   logic [2*STAT_W-1:0] gated_cycles_o;

   int tests_run    = 0;
   int tests_failed = 0;

   int     m_phase, m_streak, m_warm;
   logic   m_ack;
   longint m_events, m_cycles;

   cg_enable_ctrl #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES),
      .STAT_W(STAT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .busy_i(busy_i),
      .wake_req_i(wake_req_i),
      .wake_ack_o(wake_ack_o),
      .quiesce_req_o(quiesce_req_o),
      .quiesce_ack_i(quiesce_ack_i),
      .force_on_i(force_on_i),
      .cg_en_o(cg_en_o),
      .gated_o(gated_o),
      .gate_events_o(gate_events_o),
      .gated_cycles_o(gated_cycles_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_phase = P_ON; m_streak = 0; m_warm = 0; m_ack = 1'b0;
      m_events = 0; m_cycles = 0;
   endtask

   task automatic model_step(input logic b, input logic w, input logic f, input logic q);
      logic wk, idl;
      wk  = w | f;
      idl = !b && !wk;
      if (m_phase == P_OFF && m_cycles < (64'd1 << (2*STAT_W)) - 1) m_cycles++;
      // A requester is acknowledged only when seen in steady RUN (no idle streak).
      m_ack = (m_phase == P_ON) && (m_streak == 0) && w;
      case (m_phase)
         P_ON: begin
            if (idl) begin
               m_streak++;
               if (m_streak == IDLE_CYCLES + 1) begin
                  m_phase = P_PARK; m_streak = 0;
               end
            end else begin
               m_streak = 0;
            end
         end
         P_PARK: begin
            if (wk) m_phase = P_ON;
            else if (q && !b) begin
               m_phase = P_OFF;
               if (m_events < (64'd1 << STAT_W) - 1) m_events++;
            end
         end
         P_OFF: begin
            if (wk || b) begin m_phase = P_WARM; m_warm = WAKE_CYCLES; end
         end
         default: begin
            m_warm--;
            if (m_warm == 0) m_phase = P_ON;
         end
      endcase
   endtask

   function automatic logic [3:0] exp_outs();
      return {m_phase != P_OFF, (m_phase == P_PARK) || (m_phase == P_OFF), m_ack, m_phase == P_OFF};
   endfunction

   function automatic logic [STAT_W-1:0] exp_events();
`ifdef CG_STATS_EN
      return STAT_W'(m_events);
`else
      return '0;
`endif
   endfunction

   function automatic logic [2*STAT_W-1:0] exp_cycles();
`ifdef CG_STATS_EN
      return (2*STAT_W)'(m_cycles);
`else
      return '0;
`endif
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model, settle.
   task automatic tick(input logic b, input logic w, input logic f, input logic q);
      busy_i = b; wake_req_i = w; force_on_i = f; quiesce_ack_i = q;
      @(posedge clk);
      model_step(b, w, f, q);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      busy_i = 1'b0; wake_req_i = 1'b0; force_on_i = 1'b0; quiesce_ack_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({cg_en_o, quiesce_req_o, wake_ack_o, gated_o} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL reset_outs: got %b want 1000", {cg_en_o, quiesce_req_o, wake_ack_o, gated_o});
      end
      tests_run++;
      if (gate_events_o !== '0) begin
         tests_failed++;
         $display("FAIL reset_events: got %0d want 0", gate_events_o);
      end
      tests_run++;
      if (gated_cycles_o !== '0) begin
         tests_failed++;
         $display("FAIL reset_cycles: got %0d want 0", gated_cycles_o);
      end
   endtask

   task automatic test_idle_gating();
      for (int e = 1; e <= IDLE_CYCLES + 2; e++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b1);
         tests_run++;
         if (quiesce_req_o !== (e >= IDLE_CYCLES + 1)) begin
            tests_failed++;
            $display("FAIL idle_qreq edge %0d: got %b want %b", e, quiesce_req_o, e >= IDLE_CYCLES + 1);
         end
         tests_run++;
         if (cg_en_o !== (e < IDLE_CYCLES + 2) || gated_o !== (e >= IDLE_CYCLES + 2)) begin
            tests_failed++;
            $display("FAIL idle_cgen edge %0d: got cg_en=%b gated=%b", e, cg_en_o, gated_o);
         end
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_wake();
      for (int e = 1; e <= WAKE_CYCLES + 2; e++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b1);
         tests_run++;
         if (cg_en_o !== 1'b1 || wake_ack_o !== (e == WAKE_CYCLES + 2)) begin
            tests_failed++;
            $display("FAIL wake edge %0d: got cg_en=%b ack=%b want 1 %b", e, cg_en_o, wake_ack_o, e == WAKE_CYCLES + 2);
         end
         if (e <= WAKE_CYCLES) begin
            tests_run++;
            if (quiesce_req_o !== 1'b0) begin
               tests_failed++;
               $display("FAIL wake_qreq edge %0d: got %b want 0", e, quiesce_req_o);
            end
         end
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (wake_ack_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL wake_ack_drop: got %b want 0", wake_ack_o);
      end
   endtask

   task automatic test_hysteresis();
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < IDLE_CYCLES - 1; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int e = 1; e <= IDLE_CYCLES + 1; e++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         tests_run++;
         if (quiesce_req_o !== (e == IDLE_CYCLES + 1) || {cg_en_o, quiesce_req_o, wake_ack_o, gated_o} !== exp_outs()) begin
            tests_failed++;
            $display("FAIL hyst edge %0d: got qreq=%b want %b", e, quiesce_req_o, e == IDLE_CYCLES + 1);
         end
      end
   endtask

   task automatic test_abort_race();
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      tests_run++;
      if ({cg_en_o, quiesce_req_o, gated_o} !== 3'b100) begin
         tests_failed++;
         $display("FAIL abort_state: got cg_en/qreq/gated=%b want 100", {cg_en_o, quiesce_req_o, gated_o});
      end
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      tests_run++;
      if (cg_en_o !== 1'b1 || wake_ack_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_ack: got cg_en=%b ack=%b want 1 1", cg_en_o, wake_ack_o);
      end
      tests_run++;
`ifdef CG_STATS_EN
      if (gate_events_o !== 16'd1) begin
`else
      if (gate_events_o !== 16'd0) begin
`endif
         tests_failed++;
         $display("FAIL abort_events: got %0d", gate_events_o);
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_force_on();
      for (int i = 0; i < IDLE_CYCLES + 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (cg_en_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL force_pregate: got cg_en=%b want 0", cg_en_o);
      end
      for (int e = 1; e <= 3 * IDLE_CYCLES; e++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b1);
         tests_run++;
         if (cg_en_o !== 1'b1 || gated_o !== 1'b0 || quiesce_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL force_hold edge %0d: got cg_en=%b gated=%b qreq=%b", e, cg_en_o, gated_o, quiesce_req_o);
         end
      end
      for (int i = 0; i < IDLE_CYCLES + 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (cg_en_o !== 1'b0 || gated_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL force_regate: got cg_en=%b gated=%b want 0 1", cg_en_o, gated_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({cg_en_o, quiesce_req_o, wake_ack_o, gated_o} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL async_reset: got %b want 1000", {cg_en_o, quiesce_req_o, wake_ack_o, gated_o});
      end
      do_reset();
   endtask

   task automatic test_stats();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < IDLE_CYCLES + 2 + 9; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < WAKE_CYCLES + 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
         tick(1'b1, 1'b0, 1'b0, 1'b1);
      end
      tests_run++;
`ifdef CG_STATS_EN
      if (gate_events_o !== 16'd3 || gated_cycles_o !== 32'd30) begin
`else
      if (gate_events_o !== 16'd0 || gated_cycles_o !== 32'd0) begin
`endif
         tests_failed++;
         $display("FAIL stats_directed: got events=%0d cycles=%0d", gate_events_o, gated_cycles_o);
      end
      tests_run++;
      if (gate_events_o !== exp_events() || gated_cycles_o !== exp_cycles()) begin
         tests_failed++;
         $display("FAIL stats_model: got %0d/%0d want %0d/%0d", gate_events_o, gated_cycles_o, exp_events(), exp_cycles());
      end
   endtask

   task automatic test_random();
      logic b, w, f, q;
      int mode, len;
      w = 1'b0; f = 1'b0;
      for (int s = 0; s < 60; s++) begin
         mode = int'($urandom_range(0, 3));
         len  = int'($urandom_range(20, 60));
         for (int c = 0; c < len; c++) begin
            case (mode)
               0:       b = 1'b0;
               1:       b = ($urandom % 16) == 0;
               2:       b = $urandom % 2;
               default: b = ($urandom % 4) == 0;
            endcase
            if (($urandom % 12) == 0) w = ~w;
            if (mode == 0) w = 1'b0;
            if (($urandom % 40) == 0) f = ~f;
            if (mode == 0) f = 1'b0;
            q = ($urandom % 3) != 0;
            tick(b, w, f, q);
            tests_run++;
            if ({cg_en_o, quiesce_req_o, wake_ack_o, gated_o} !== exp_outs()) begin
               tests_failed++;
               $display("FAIL rand_outs seg %0d cyc %0d: got %b want %b", s, c, {cg_en_o, quiesce_req_o, wake_ack_o, gated_o}, exp_outs());
            end
            tests_run++;
            if (gate_events_o !== exp_events() || gated_cycles_o !== exp_cycles()) begin
               tests_failed++;
               $display("FAIL rand_stats seg %0d cyc %0d: got %0d/%0d want %0d/%0d", s, c, gate_events_o, gated_cycles_o, exp_events(), exp_cycles());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_gating();
      test_wake();
      test_hysteresis();
      test_abort_race();
      test_force_on();
      test_stats();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
